// File: rtl/leaf_stream_packetizer_if.sv
// Stream-in / packet-out bundle of the leaf packetizer.
// master: kernel+BFT side; slave: the packetizer.
interface leaf_stream_packetizer_if #(
  parameter int PAYLOAD_BITS = 32,
  parameter int PACKET_BITS  = 49
);
  logic [PAYLOAD_BITS-1:0] din_user;
  logic                    vld_user;
  logic                    ack_user;
  logic [PACKET_BITS-1:0]  dout_packet;
  logic                    packet_ack;

  modport master (
    output din_user,
    output vld_user,
    input  ack_user,
    input  dout_packet,
    output packet_ack
  );

  modport slave (
    input  din_user,
    input  vld_user,
    output ack_user,
    output dout_packet,
    input  packet_ack
  );
endinterface

// File: rtl/leaf_stream_packetizer.sv
// Wraps user stream words into BFT packets for one dest leaf/port.
// Ports: clk, ap_rst_n, cfg_*, credit_update/count, s (stream+packet).
module leaf_stream_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int INIT_CREDITS          = 128
) (
  input  logic                     clk,
  input  logic                     ap_rst_n,
  input  logic                     cfg_wr_en,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
  output logic                     cfg_done,
  output logic                     cfg_err,
  leaf_stream_packetizer_if.slave  s,
  input  logic                     credit_update,
  output logic [NUM_ADDR_BITS:0]   credit_count
);

  localparam int CW = NUM_ADDR_BITS + 1;

  localparam logic [CW:0] UPD_W =
    FREESPACE_UPDATE_SIZE[CW:0];
  localparam logic [CW:0] INIT_W =
    INIT_CREDITS[CW:0];

  typedef enum logic {
    UNCFG,
    RUN
  } state_t;

  state_t                   state;
  logic [NUM_LEAF_BITS-1:0] leaf;
  logic [NUM_PORT_BITS-1:0] port;
  logic [NUM_ADDR_BITS-1:0] wr_ptr;

  logic                     out_valid;
  logic                     accept;
  logic                     reconfig;
  logic [NUM_LEAF_BITS-1:0] sel_leaf;
  logic [NUM_PORT_BITS-1:0] sel_port;
  logic [NUM_ADDR_BITS-1:0] sel_ptr;
  logic [CW:0]              cred_sum;
  logic [CW-1:0]            cred_next;
  logic [PACKET_BITS-1:0]   next_pkt;

  assign out_valid = s.dout_packet[PACKET_BITS-1];

  assign s.ack_user = (state == RUN)
                   && (credit_count != '0)
                   && (!out_valid || s.packet_ack);

  assign accept = s.vld_user && s.ack_user;

  // Idle reconfigure restarts pointer and credits; a word
  // accepted in that same cycle is sent with the new target.
  assign reconfig = (state == RUN) && cfg_wr_en
                 && !out_valid;

  assign sel_leaf = reconfig ? cfg_dest_leaf : leaf;
  assign sel_port = reconfig ? cfg_dest_port : port;
  assign sel_ptr  = reconfig ? '0 : wr_ptr;

  always_comb begin
    cred_sum = reconfig ? INIT_W : {1'b0, credit_count};
    if (credit_update && !reconfig) begin
      cred_sum = cred_sum + UPD_W;
    end
    if (accept) begin
      cred_sum = cred_sum - 1'b1;
    end
    // Saturate so returned credits never exceed the
    // remote buffer depth.
    if (cred_sum > INIT_W) begin
      cred_next = INIT_W[CW-1:0];
    end else begin
      cred_next = cred_sum[CW-1:0];
    end
  end

  assign next_pkt = {1'b1, sel_leaf, sel_port,
                     sel_ptr, s.din_user};

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state         <= UNCFG;
      leaf          <= '0;
      port          <= '0;
      wr_ptr        <= '0;
      credit_count  <= INIT_W[CW-1:0];
      s.dout_packet <= '0;
      cfg_done      <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      unique case (1'b1)
        (state == UNCFG): begin
          if (cfg_wr_en) begin
            state        <= RUN;
            leaf         <= cfg_dest_leaf;
            port         <= cfg_dest_port;
            wr_ptr       <= '0;
            credit_count <= INIT_W[CW-1:0];
            cfg_done     <= 1'b1;
          end
        end
        (state == RUN): begin
          if (cfg_wr_en && out_valid) begin
            cfg_err <= 1'b1;
          end
          if (reconfig) begin
            leaf <= cfg_dest_leaf;
            port <= cfg_dest_port;
          end
          credit_count <= cred_next;
          if (accept) begin
            wr_ptr <= sel_ptr + 1'b1;
          end else begin
            wr_ptr <= sel_ptr;
          end
          if (accept) begin
            s.dout_packet <= next_pkt;
          end else if (s.packet_ack) begin
            s.dout_packet <= '0;
          end
        end
        default: begin
          state <= UNCFG;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Self-checking bench for leaf_stream_packetizer.
// Vector table, directed corner cases, random vs model.
module tb_leaf_stream_packetizer;

  logic       clk = 1'b0;
  logic       ap_rst_n = 1'b1;
  logic       cfg_wr_en = 1'b0;
  logic [4:0] cfg_dest_leaf = '0;
  logic [3:0] cfg_dest_port = '0;
  logic       cfg_done;
  logic       cfg_err;
  logic       credit_update = 1'b0;
  logic [7:0] credit_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  leaf_stream_packetizer_if bus ();

  leaf_stream_packetizer dut (
    .clk           (clk),
    .ap_rst_n      (ap_rst_n),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_dest_leaf (cfg_dest_leaf),
    .cfg_dest_port (cfg_dest_port),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err),
    .s             (bus),
    .credit_update (credit_update),
    .credit_count  (credit_count)
  );

  typedef struct {
    logic        vld;
    logic [31:0] din;
    logic        pa;
    logic        up;
    logic        exp_ack;
    logic [48:0] exp_pkt;
    logic [7:0]  exp_cred;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [48:0] mkpkt(
    input logic [4:0]  l,
    input logic [3:0]  p,
    input logic [6:0]  a,
    input logic [31:0] d
  );
    return {1'b1, l, p, a, d};
  endfunction

  task automatic check(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(
    input logic        v,
    input logic [31:0] d,
    input logic        pa,
    input logic        up
  );
    bus.vld_user   = v;
    bus.din_user   = d;
    bus.packet_ack = pa;
    credit_update  = up;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic configure(
    input logic [4:0] l,
    input logic [3:0] p
  );
    drive(1'b0, '0, 1'b0, 1'b0);
    cfg_dest_leaf = l;
    cfg_dest_port = p;
    cfg_wr_en     = 1'b1;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  logic [48:0] held;
  logic [48:0] mpkt;
  int          mcred;
  int          mcount;
  logic        v, pa, up, eack, acc;
  logic [31:0] d;

  initial begin
    tbl[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1,
               mkpkt(5'd5, 4'd2, 7'd0, 32'hDEADBEEF), 8'd127};
    tbl[1] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0,
               mkpkt(5'd5, 4'd2, 7'd0, 32'hDEADBEEF), 8'd127};
    tbl[2] = '{1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0,
               mkpkt(5'd5, 4'd2, 7'd0, 32'hDEADBEEF), 8'd127};
    tbl[3] = '{1'b1, 32'h22222222, 1'b1, 1'b0, 1'b1,
               mkpkt(5'd5, 4'd2, 7'd1, 32'h22222222), 8'd126};
    tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1,
               49'd0, 8'd126};
    tbl[5] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1,
               49'd0, 8'd128};
    tbl[6] = '{1'b1, 32'h33333333, 1'b0, 1'b1, 1'b1,
               mkpkt(5'd5, 4'd2, 7'd2, 32'h33333333), 8'd128};
    tbl[7] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1,
               49'd0, 8'd128};

    drive(1'b0, '0, 1'b0, 1'b0);
    #2 ap_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dout", bus.dout_packet, 0);
    check("rst_ack", bus.ack_user, 0);
    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_cred", credit_count, 128);
    ap_rst_n = 1'b1;
    tick();

    drive(1'b1, 32'h1234, 1'b1, 1'b0);
    check("uncfg_ack", bus.ack_user, 0);
    tick();
    check("uncfg_dout", bus.dout_packet, 0);

    configure(5'd5, 4'd2);
    check("cfg_done", cfg_done, 1);
    check("cfg_cred", credit_count, 128);

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].vld, tbl[i].din, tbl[i].pa, tbl[i].up);
      check($sformatf("tbl%0d_ack", i),
            bus.ack_user, tbl[i].exp_ack);
      tick();
      check($sformatf("tbl%0d_pkt", i),
            bus.dout_packet, tbl[i].exp_pkt);
      check($sformatf("tbl%0d_cred", i),
            credit_count, tbl[i].exp_cred);
    end

    // 130 words against 128 credits, address wrap
    configure(5'd5, 4'd2);
    for (int i = 0; i < 130; i++) begin
      drive(1'b1, 32'h1000 + i, 1'b1, 1'b0);
      check("burst_ack", bus.ack_user, i < 128);
      tick();
      if (i < 128) begin
        check("burst_pkt", bus.dout_packet,
              mkpkt(5'd5, 4'd2, 7'(i), 32'h1000 + i));
      end
    end
    check("burst_cred0", credit_count, 0);
    check("burst_ack0", bus.ack_user, 0);
    check("burst_drained", bus.dout_packet, 0);
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    check("upd_cred64", credit_count, 64);
    drive(1'b1, 32'hAAAA0000, 1'b1, 1'b0);
    check("upd_ack", bus.ack_user, 1);
    tick();
    held = mkpkt(5'd5, 4'd2, 7'd0, 32'hAAAA0000);
    check("wrap_addr0", bus.dout_packet, held);
    check("wrap_cred", credit_count, 63);

    // back-pressure hold, then no-bubble release
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hBBBB0001, 1'b0, 1'b0);
      check("hold_ack", bus.ack_user, 0);
      tick();
      check("hold_pkt", bus.dout_packet, held);
    end
    drive(1'b1, 32'hBBBB0001, 1'b1, 1'b0);
    check("rel_ack", bus.ack_user, 1);
    tick();
    check("rel_pkt", bus.dout_packet,
          mkpkt(5'd5, 4'd2, 7'd1, 32'hBBBB0001));
    check("rel_cred", credit_count, 62);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check("rel_drain", bus.dout_packet, 0);

    // update coincident with accept, saturation
    configure(5'd5, 4'd2);
    for (int i = 0; i < 118; i++) begin
      drive(1'b1, i, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check("cred10", credit_count, 10);
    drive(1'b1, 32'hCCCC0000, 1'b1, 1'b1);
    check("co_ack", bus.ack_user, 1);
    tick();
    check("co_cred73", credit_count, 73);
    check("co_pkt", bus.dout_packet,
          mkpkt(5'd5, 4'd2, 7'd118, 32'hCCCC0000));
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    check("sat_cred", credit_count, 128);
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    check("sat_cred2", credit_count, 128);

    // configure while pending is rejected
    drive(1'b1, 32'hDDDD0000, 1'b0, 1'b0);
    tick();
    held = mkpkt(5'd5, 4'd2, 7'd119, 32'hDDDD0000);
    check("pend_pkt", bus.dout_packet, held);
    drive(1'b0, '0, 1'b0, 1'b0);
    cfg_dest_leaf = 5'd9;
    cfg_dest_port = 4'd7;
    cfg_wr_en = 1'b1;
    tick();
    cfg_wr_en = 1'b0;
    check("err_pulse", cfg_err, 1);
    check("err_hold", bus.dout_packet, held);
    tick();
    check("err_clear", cfg_err, 0);
    drive(1'b1, 32'hEEEE0000, 1'b1, 1'b0);
    tick();
    check("err_keep", bus.dout_packet,
          mkpkt(5'd5, 4'd2, 7'd120, 32'hEEEE0000));
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    configure(5'd31, 4'd3);
    check("recfg_err", cfg_err, 0);
    drive(1'b1, 32'hFFFF0000, 1'b0, 1'b0);
    tick();
    check("recfg_pkt", bus.dout_packet,
          mkpkt(5'd31, 4'd3, 7'd0, 32'hFFFF0000));
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();

    // random traffic vs reference model
    configure(5'd17, 4'd9);
    mpkt   = '0;
    mcred  = 128;
    mcount = 0;
    for (int c = 0; c < 1500; c++) begin
      check("rnd_pkt", bus.dout_packet, mpkt);
      check("rnd_cred", credit_count, mcred);
      v  = ($urandom % 5) != 0;
      d  = $urandom;
      pa = ($urandom % 3) != 0;
      up = ($urandom % 40) == 0;
      drive(v, d, pa, up);
      eack = (mcred != 0) && (!mpkt[48] || pa);
      check("rnd_ack", bus.ack_user, eack);
      acc = v && eack;
      if (acc) begin
        mpkt = mkpkt(5'd17, 4'd9, 7'(mcount % 128), d);
        mcount++;
      end else if (pa) begin
        mpkt = '0;
      end
      mcred = mcred + (up ? 64 : 0) - (acc ? 1 : 0);
      if (mcred > 128) mcred = 128;
      tick();
    end

    // asynchronous reset with a packet pending
    drive(1'b1, 32'h12340000, 1'b0, 1'b0);
    tick();
    #2 ap_rst_n = 1'b0;
    #1;
    check("arst_dout", bus.dout_packet, 0);
    check("arst_done", cfg_done, 0);
    check("arst_cred", credit_count, 128);
    @(negedge clk);
    ap_rst_n = 1'b1;
    drive(1'b1, 32'h55550000, 1'b1, 1'b0);
    check("arst_ack", bus.ack_user, 0);
    tick();
    check("arst_ign", bus.dout_packet, 0);
    tick();
    check("arst_ign2", bus.dout_packet, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
